cart_mem_fetch: RTL

- Downstream stage of the cartridge mapper (ASCII16 and siblings). Consumes the mapper's translated ROM address and strobes plus its SRAM window strobes.
- Turns CPU reads into handshaked SDRAM read requests or synchronous backup-SRAM block-RAM accesses, and drives CPU wait while a fetch is outstanding.
- Holds a one-entry byte cache of the last ROM fetch, times out dead SDRAM requests, and returns the byte to the slot data mux.

---
 rtl/cart_pkg.sv | 6 +
 rtl/cart_byte_cache.sv | 36 +++
 rtl/cart_mem_fetch.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cart_pkg.sv
// cart_pkg: shared types and constants for the cartridge memory fetch path
package cart_pkg;
  localparam int CART_AW = 25;
  localparam logic [7:0] UNMAPPED = 8'hFF;
  typedef enum logic [1:0] {IDLE, SRAM_RD, SDRAM_REQ, DONE} state_e;
endpackage

// File: rtl/cart_byte_cache.sv
// cart_byte_cache: one-entry ROM byte cache with a full-address tag; flush beats a fill
module cart_byte_cache
  import cart_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               fill,
  input  logic [CART_AW-1:0] fill_tag,
  input  logic [7:0]         fill_data,
  input  logic [CART_AW-1:0] lookup_addr,
  output logic               hit,
  output logic [7:0]         data
);
  logic               valid_q, valid_d;
  logic [CART_AW-1:0] tag_q, tag_d;
  logic [7:0]         data_q, data_d;
  always_comb begin
    valid_d = flush ? 1'b0 : (fill | valid_q);
    tag_d   = fill ? fill_tag : tag_q;
    data_d  = fill ? fill_data : data_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= UNMAPPED;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end
  assign hit  = valid_q && (tag_q == lookup_addr);
  assign data = data_q;
endmodule

// File: rtl/cart_mem_fetch.sv
// cart_mem_fetch: serves CPU reads from backup SRAM, a one-byte ROM cache or a handshaked
// SDRAM fetch, stalling the CPU while a fetch is outstanding.
module cart_mem_fetch
  import cart_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int SRAM_AW = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cs,
  input  logic               rd,
  input  logic               wr,
  input  logic [7:0]         d_from_cpu,
  input  logic [CART_AW-1:0] mem_addr,
  input  logic               mem_oe,
  input  logic [SRAM_AW-1:0] sram_addr,
  input  logic               sram_we,
  input  logic               sram_oe,
  input  logic               flush,
  output logic               sdram_req,
  output logic [CART_AW-1:0] sdram_addr,
  input  logic               sdram_ack,
  input  logic [7:0]         sdram_q,
  output logic [SRAM_AW-1:0] bram_addr,
  output logic               bram_we,
  output logic [7:0]         bram_d,
  input  logic [7:0]         bram_q,
  output logic [7:0]         d_to_cpu,
  output logic               wait_n,
  output logic               err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e             state_q, state_d;
  logic               rd_prev_q, wr_prev_q;
  logic               req_q, req_d, err_q, err_d;
  logic [CART_AW-1:0] addr_q, addr_d;
  logic [7:0]         dout_q, dout_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               wpend_q, wpend_d;
  logic [SRAM_AW-1:0] waddr_q, waddr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               rd_lvl, wr_lvl, start, acc_wr, hit, fill;
  logic [7:0]         cache_data;
  assign rd_lvl = cs & rd;
  assign wr_lvl = cs & wr;
  assign start  = rd_lvl & ~rd_prev_q;
  assign acc_wr = wr_lvl & ~wr_prev_q & sram_we;
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    fill    = 1'b0;
    wait_n  = 1'b1;
    // the BRAM port is busy reading in SRAM_RD, so a write there lands one cycle later
    wpend_d   = acc_wr && state_q == SRAM_RD;
    waddr_d   = wpend_d ? sram_addr : waddr_q;
    wdata_d   = wpend_d ? d_from_cpu : wdata_q;
    bram_we   = wpend_q | (acc_wr && state_q != SRAM_RD);
    bram_addr = wpend_q ? waddr_q : sram_addr;
    bram_d    = wpend_q ? wdata_q : d_from_cpu;
    case (state_q)
      IDLE: if (start) begin
        if (sram_oe) begin
          wait_n  = 1'b0;
          state_d = SRAM_RD;
        end else if (mem_oe && hit) begin
          dout_d  = cache_data;
          state_d = DONE;
        end else if (mem_oe) begin
          wait_n  = 1'b0;
          req_d   = 1'b1;
          addr_d  = mem_addr;
          cnt_d   = '0;
          state_d = SDRAM_REQ;
        end else begin
          dout_d  = UNMAPPED;
          state_d = DONE;
        end
      end
      SRAM_RD: begin
        dout_d  = bram_q;
        state_d = DONE;
      end
      SDRAM_REQ: begin
        wait_n = 1'b0;
        cnt_d  = cnt_q + 1'b1;
        if (sdram_ack) begin
          req_d   = 1'b0;
          dout_d  = sdram_q;
          fill    = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          dout_d  = UNMAPPED;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = rd_lvl ? DONE : IDLE;
    endcase
  end
  // rd_prev resets high so a strobe caught by reset is treated as already served
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rd_prev_q <= 1'b1;
      wr_prev_q <= 1'b1;
      req_q     <= 1'b0;
      addr_q    <= '0;
      dout_q    <= UNMAPPED;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      wpend_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_prev_q <= rd_lvl;
      wr_prev_q <= wr_lvl;
      req_q     <= req_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      wpend_q   <= wpend_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end
  cart_byte_cache u_cache (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .fill       (fill),
    .fill_tag   (addr_q),
    .fill_data  (sdram_q),
    .lookup_addr(mem_addr),
    .hit        (hit),
    .data       (cache_data)
  );
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;
  assign d_to_cpu   = dout_q;
  assign err        = err_q;
endmodule
